prng_sched: RTL

Round-robin scheduler that shares one external `prng` LFSR instance between `NREQ` requesters. It sequences the generator's `update` and `reseed` controls, advances the LFSR `STEPS` times per delivered word, and forwards host reseed requests. It also recovers the LFSR from the all-zero lock-up state, including the state left by the generator's own reset. It sits between the `prng` datapath and its consumers.

---
 rtl/prng_sched.sv | 125 ++++++++++++
 1 files changed

// File: rtl/prng_sched.sv
// Round-robin scheduler that shares one external LFSR prng between NREQ requesters,
// sequencing its update/reseed strobes and recovering it from the all-zero lock-up state.
module prng_sched #(
  parameter int               WIDTH        = 8,
  parameter int               NREQ         = 4,
  parameter int               STEPS        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant,
  output logic             rvalid,
  output logic [WIDTH-1:0] rdata,
  input  logic             seed_req,
  input  logic [WIDTH-1:0] seed_in,
  output logic             seed_ack,
  output logic             busy,
  output logic             prng_update,
  output logic             prng_reseed,
  output logic [WIDTH-1:0] prng_seed,
  input  logic [WIDTH-1:0] prng_rand
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE,
    ADVANCE,
    GRANT,
    RESEED
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [IW-1:0]    sel, sel_nxt;
  logic [IW-1:0]    last, last_nxt;
  logic [WIDTH-1:0] seed_q, seed_nxt;
  logic             host_q, host_nxt;

  logic             rr_found;
  logic [IW-1:0]    rr_pick;

  // First requester at or after last+1, wrapping; the scan order is what gives fairness.
  always_comb begin
    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    rr_found = 1'b0;
    rr_pick  = last;
    for (int k = 1; k <= NREQ; k++) begin
      if (!rr_found && req[(int'(last) + k) % NREQ]) begin
        rr_found = 1'b1;
        rr_pick  = IW'((int'(last) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    last_nxt  = last;
    seed_nxt  = seed_q;
    host_nxt  = host_q;
    case (state)
      IDLE: begin
        // A host reseed outranks lock-up recovery, which outranks word requests.
        if (seed_req) begin
          state_nxt = RESEED;
          seed_nxt  = (seed_in == '0) ? DEFAULT_SEED : seed_in;
          host_nxt  = 1'b1;
        end else if (prng_rand == '0) begin
          state_nxt = RESEED;
          seed_nxt  = DEFAULT_SEED;
          host_nxt  = 1'b0;
        end else if (rr_found) begin
          state_nxt = ADVANCE;
          cnt_nxt   = CW'(STEPS);
          sel_nxt   = rr_pick;
        end
      end
      ADVANCE: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = GRANT;
      end
      GRANT: begin
        last_nxt  = sel;
        state_nxt = IDLE;
      end
      RESEED:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: all state here is a small register set, so every element takes a synchronous reset value.
    if (!nRst) begin
      state  <= IDLE;
      cnt    <= '0;
      sel    <= '0;
      last   <= IW'(NREQ - 1);
      seed_q <= '0;
      host_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sel    <= sel_nxt;
      last   <= last_nxt;
      seed_q <= seed_nxt;
      host_q <= host_nxt;
    end
  end

  // prng_seed follows the seed register, so it holds its value outside RESEED.
  assign busy        = (state != IDLE);
  assign prng_update = (state == ADVANCE);
  assign prng_reseed = (state == RESEED);
  assign prng_seed   = seed_q;
  assign seed_ack    = (state == RESEED) && host_q;
  assign rvalid      = (state == GRANT);
  assign rdata       = rvalid ? prng_rand : '0;
  assign grant       = rvalid ? (NREQ'(1) << sel) : '0;

endmodule
